// File: rtl/nabp_swap_control.sv
// nabp_swap_control: responder side of the swap / next-iteration handshake.
// Prefetches per-angle accumulator constants into a shadow set and promotes them on swap.
module nabp_swap_control #(
   parameter int pAngleWidth   = 9,
   parameter int pNoOfAngles   = 180,
   parameter int pAngleStep    = 1,
   parameter int pNoOfLineItrs = 4,
   parameter int pLineItrWidth = 2,
   parameter int pShBaseWidth  = 16,
   parameter int pMpPartWidth  = 12,
   parameter int pMpInitWidth  = 16,
   parameter int pMpBaseWidth  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic [pAngleWidth-1:0]   lut_angle,
   input  logic [pShBaseWidth-1:0]  lut_sh_accu_base,
   input  logic [pMpPartWidth-1:0]  lut_mp_accu_part,
   input  logic [pMpBaseWidth-1:0]  lut_mp_accu_base,
   output logic [pShBaseWidth-1:0]  sw_sh_accu_base,
   output logic [pMpInitWidth-1:0]  sw_mp_accu_init,
   output logic [pMpBaseWidth-1:0]  sw_mp_accu_base,
   output logic [pAngleWidth-1:0]   sw_angle,
   output logic [pLineItrWidth-1:0] sw_line_itr,
   input  logic                     sw_swap,
   input  logic                     sw_next_itr,
   output logic                     sw_swap_ack,
   output logic                     sw_next_itr_ack,
   output logic                     busy,
   output logic                     done
);

   localparam logic [pAngleWidth-1:0]   kStep    = pAngleWidth'(pAngleStep);
   localparam logic [pAngleWidth-1:0]   kLast    = pAngleWidth'((pNoOfAngles - 1) * pAngleStep);
   localparam logic [pLineItrWidth-1:0] kLastItr = pLineItrWidth'(pNoOfLineItrs - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_HOLD
   } state_t;

   state_t state, state_nx;

   logic [pAngleWidth-1:0]  fetch_angle;
   logic                    fetch_nxt;
   logic                    cap_nxt;
   logic                    primed;
   logic [pShBaseWidth-1:0] sh_sh_base;
   logic [pMpPartWidth-1:0] sh_mp_part;
   logic [pMpBaseWidth-1:0] sh_mp_base;
   logic [pAngleWidth-1:0]  sh_angle;
   logic                    sh_nxt;
   logic                    sh_valid;

   logic next_take;
   logic swap_take;
   logic issue;
   logic capture;
   logic prime;
   logic finish;
   logic advance;
   logic promote_lut;
   logic promote_sh;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (start) state_nx = S_ISSUE;
         S_ISSUE:   state_nx = S_WAIT;
         S_WAIT:    state_nx = S_CAPTURE;
         S_CAPTURE: state_nx = (prime || swap_take) ? S_ISSUE : S_HOLD;
         S_HOLD:    if (swap_take) state_nx = S_ISSUE;
         default:   state_nx = S_IDLE;
      endcase
      if (finish) state_nx = S_IDLE;
   end

   // Fresh LUT data in CAPTURE may be swapped straight through, bypassing the shadow;
   // the *_nxt tags keep a wrapped prefetch out until next_itr is acknowledged.
   always_comb begin
      next_take   = (state != S_IDLE) && sw_next_itr && !sw_next_itr_ack;
      finish      = next_take && (sw_line_itr == kLastItr);
      advance     = next_take && (sw_line_itr != kLastItr);
      swap_take   = sw_swap && !sw_swap_ack && !next_take &&
                    (((state == S_CAPTURE) && primed && !cap_nxt) ||
                     ((state == S_HOLD) && sh_valid && !sh_nxt));
      issue       = (state == S_ISSUE) && !finish;
      capture     = (state == S_CAPTURE) && !finish;
      prime       = capture && !primed;
      promote_lut = capture && (prime || swap_take);
      promote_sh  = (state == S_HOLD) && swap_take;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lut_angle       <= '0;
         sw_sh_accu_base <= '0;
         sw_mp_accu_init <= '0;
         sw_mp_accu_base <= '0;
         sw_angle        <= '0;
         sw_line_itr     <= '0;
         sw_swap_ack     <= 1'b0;
         sw_next_itr_ack <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         fetch_angle     <= '0;
         fetch_nxt       <= 1'b0;
         cap_nxt         <= 1'b0;
         primed          <= 1'b0;
         sh_sh_base      <= '0;
         sh_mp_part      <= '0;
         sh_mp_base      <= '0;
         sh_angle        <= '0;
         sh_nxt          <= 1'b0;
         sh_valid        <= 1'b0;
      end else begin
         sw_swap_ack     <= swap_take;
         sw_next_itr_ack <= next_take;
         done            <= finish;
         if ((state == S_IDLE) && start) begin
            busy        <= 1'b1;
            primed      <= 1'b0;
            fetch_angle <= '0;
            fetch_nxt   <= 1'b0;
            cap_nxt     <= 1'b0;
            sh_valid    <= 1'b0;
            sh_nxt      <= 1'b0;
            sw_line_itr <= '0;
         end
         if (finish) begin
            busy     <= 1'b0;
            sh_valid <= 1'b0;
         end
         if (issue) begin
            lut_angle <= fetch_angle;
            cap_nxt   <= fetch_nxt;
            if (fetch_angle == kLast) begin
               fetch_angle <= '0;
               fetch_nxt   <= 1'b1;
            end else begin
               fetch_angle <= fetch_angle + kStep;
            end
         end
         if (promote_lut) begin
            sw_sh_accu_base <= lut_sh_accu_base;
            sw_mp_accu_init <= pMpInitWidth'(signed'(lut_mp_accu_part));
            sw_mp_accu_base <= lut_mp_accu_base;
            sw_angle        <= lut_angle;
            primed          <= 1'b1;
         end else if (capture) begin
            sh_sh_base <= lut_sh_accu_base;
            sh_mp_part <= lut_mp_accu_part;
            sh_mp_base <= lut_mp_accu_base;
            sh_angle   <= lut_angle;
            sh_nxt     <= cap_nxt;
            sh_valid   <= 1'b1;
         end
         if (promote_sh) begin
            sw_sh_accu_base <= sh_sh_base;
            sw_mp_accu_init <= pMpInitWidth'(signed'(sh_mp_part));
            sw_mp_accu_base <= sh_mp_base;
            sw_angle        <= sh_angle;
            sh_valid        <= 1'b0;
         end
         // Anything already fetched for the next iteration now belongs to the current one.
         if (advance) begin
            sw_line_itr <= sw_line_itr + 1'b1;
            fetch_nxt   <= 1'b0;
            cap_nxt     <= 1'b0;
            sh_nxt      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nabp_swap_control.sv
// tb_nabp_swap_control: directed bench for nabp_swap_control with a clocked LUT model
// (4 angles, step 45, 2 line iterations).
module tb_nabp_swap_control;

   logic        clk;
   logic        reset;
   logic        start;
   logic [8:0]  lut_angle;
   logic [15:0] lut_sh_accu_base;
   logic [11:0] lut_mp_accu_part;
   logic [15:0] lut_mp_accu_base;
   logic [15:0] sw_sh_accu_base;
   logic [15:0] sw_mp_accu_init;
   logic [15:0] sw_mp_accu_base;
   logic [8:0]  sw_angle;
   logic [1:0]  sw_line_itr;
   logic        sw_swap;
   logic        sw_next_itr;
   logic        sw_swap_ack;
   logic        sw_next_itr_ack;
   logic        busy;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;

   nabp_swap_control #(
      .pAngleWidth(9), .pNoOfAngles(4), .pAngleStep(45), .pNoOfLineItrs(2),
      .pLineItrWidth(2), .pShBaseWidth(16), .pMpPartWidth(12),
      .pMpInitWidth(16), .pMpBaseWidth(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .lut_angle(lut_angle),
      .lut_sh_accu_base(lut_sh_accu_base), .lut_mp_accu_part(lut_mp_accu_part),
      .lut_mp_accu_base(lut_mp_accu_base), .sw_sh_accu_base(sw_sh_accu_base),
      .sw_mp_accu_init(sw_mp_accu_init), .sw_mp_accu_base(sw_mp_accu_base),
      .sw_angle(sw_angle), .sw_line_itr(sw_line_itr), .sw_swap(sw_swap),
      .sw_next_itr(sw_next_itr), .sw_swap_ack(sw_swap_ack),
      .sw_next_itr_ack(sw_next_itr_ack), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] part_of(input logic [8:0] a);
      case (a)
         9'd0:    return 12'd7;
         9'd45:   return 12'hFFD;
         9'd90:   return 12'h800;
         9'd135:  return 12'd100;
         default: return 12'd0;
      endcase
   endfunction

   // Clocked LUTs: register lut_angle, outputs valid one edge later.
   always @(posedge clk) begin
      lut_sh_accu_base <= 16'h1000 + 16'(lut_angle);
      lut_mp_accu_part <= part_of(lut_angle);
      lut_mp_accu_base <= 16'hA000 ^ 16'(lut_angle);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_swap(input int max, output int n);
      n = -1;
      for (int i = 0; i < max; i++) begin
         tick();
         if (sw_swap_ack) begin
            n = i + 1;
            break;
         end
      end
   endtask

   int  n;
   logic any;

   initial begin
      reset = 1'b1; start = 1'b0; sw_swap = 1'b0; sw_next_itr = 1'b0;
      tick(); tick();
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_angle", 32'(sw_angle), 32'd0);
      chk("rst_base",  32'(sw_sh_accu_base), 32'd0);
      chk("rst_acks",  32'({sw_swap_ack, sw_next_itr_ack, done}), 32'd0);

      // 1: start and priming
      reset = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      tick(); tick(); tick();
      chk("prime_angle", 32'(sw_angle), 32'd0);
      chk("prime_sh",    32'(sw_sh_accu_base), 32'h1000);
      chk("prime_init",  32'(sw_mp_accu_init), 32'h0007);
      chk("prime_base",  32'(sw_mp_accu_base), 32'hA000);
      chk("prime_acks",  32'({sw_swap_ack, sw_next_itr_ack}), 32'd0);

      // 2: swap to angle 45
      sw_swap = 1'b1;
      wait_swap(8, n);
      chk("swap45_lat",  32'(n), 32'd3);
      chk("swap45_ang",  32'(sw_angle), 32'd45);
      chk("swap45_init", 32'(sw_mp_accu_init), 32'hFFFD);
      chk("swap45_sh",   32'(sw_sh_accu_base), 32'h102D);
      chk("swap45_base", 32'(sw_mp_accu_base), 32'hA02D);

      // 3: request still high in the ack cycle is ignored; next ack within 3 cycles
      tick();
      chk("reswap_ignored", 32'(sw_swap_ack), 32'd0);
      wait_swap(8, n);
      chk("reswap_gap", 32'((n >= 0) && (n + 1 <= 3)), 32'd1);
      chk("swap90_ang",  32'(sw_angle), 32'd90);
      chk("swap90_init", 32'(sw_mp_accu_init), 32'hF800);

      // 4: last angle, then wrapped prefetch blocked until next_itr
      wait_swap(8, n);
      chk("swap135_ang",  32'(sw_angle), 32'd135);
      chk("swap135_init", 32'(sw_mp_accu_init), 32'h0064);
      any = 1'b0;
      repeat (6) begin
         tick();
         any = any | sw_swap_ack;
      end
      chk("wrap_no_ack", 32'(any), 32'd0);
      sw_next_itr = 1'b1;
      tick();
      chk("nxt1_ack",  32'(sw_next_itr_ack), 32'd1);
      chk("nxt1_itr",  32'(sw_line_itr), 32'd1);
      chk("nxt1_swp",  32'(sw_swap_ack), 32'd0);
      chk("nxt1_ang",  32'(sw_angle), 32'd135);
      sw_next_itr = 1'b0;
      tick();
      chk("wrap_swap_ack", 32'(sw_swap_ack), 32'd1);
      chk("wrap_ang",      32'(sw_angle), 32'd0);
      chk("wrap_nxt_ack",  32'(sw_next_itr_ack), 32'd0);
      sw_swap = 1'b0;

      // 6a: next_itr on last iteration ends the run
      sw_next_itr = 1'b1;
      tick();
      chk("last_ack",  32'(sw_next_itr_ack), 32'd1);
      chk("last_done", 32'(done), 32'd1);
      chk("last_busy", 32'(busy), 32'd0);
      sw_next_itr = 1'b0;
      tick();
      chk("done_pulse", 32'(done), 32'd0);
      chk("hold_ang",   32'(sw_angle), 32'd0);
      chk("hold_itr",   32'(sw_line_itr), 32'd1);
      sw_swap = 1'b1; sw_next_itr = 1'b1;
      any = 1'b0;
      repeat (3) begin
         tick();
         any = any | sw_swap_ack | sw_next_itr_ack;
      end
      chk("idle_no_ack", 32'(any), 32'd0);
      sw_swap = 1'b0; sw_next_itr = 1'b0;

      // 5: simultaneous swap and next_itr
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run2_itr", 32'(sw_line_itr), 32'd0);
      repeat (6) tick();
      sw_swap = 1'b1; sw_next_itr = 1'b1;
      tick();
      chk("both_nxt_ack", 32'(sw_next_itr_ack), 32'd1);
      chk("both_swp_ack", 32'(sw_swap_ack), 32'd0);
      chk("both_itr",     32'(sw_line_itr), 32'd1);
      sw_next_itr = 1'b0;
      tick();
      chk("both_swp_late", 32'(sw_swap_ack), 32'd1);
      chk("both_nxt_low",  32'(sw_next_itr_ack), 32'd0);
      chk("both_ang",      32'(sw_angle), 32'd45);
      sw_swap = 1'b0;

      // 6b: reset during WAIT
      tick();
      chk("pre_rst_lut", 32'(lut_angle), 32'd90);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_lut",  32'(lut_angle), 32'd0);
      chk("mid_rst_ang",  32'(sw_angle), 32'd0);
      chk("mid_rst_itr",  32'(sw_line_itr), 32'd0);
      chk("mid_rst_init", 32'(sw_mp_accu_init), 32'd0);
      sw_swap = 1'b1; sw_next_itr = 1'b1;
      any = 1'b0;
      repeat (4) begin
         tick();
         any = any | sw_swap_ack | sw_next_itr_ack | busy;
      end
      chk("post_rst_no_ack", 32'(any), 32'd0);
      sw_swap = 1'b0; sw_next_itr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
